pwr_gate_seq: RTL and testbench



---
 rtl/pwr_gate_seq_pkg.sv | 47 ++++
 rtl/pg_dwell_cnt.sv | 33 +++
 rtl/pwr_gate_seq.sv | 137 +++++++++++++
 tb/tb_pwr_gate_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pwr_gate_seq_pkg.sv
// pwr_gate_seq_pkg: shared types for the power-gating sequencer.
//   pg_state_e : sequencer states with fixed 4-bit encodings (visible on STATE)
//   pg_out_t   : Moore output vector driven towards the switchable domain
//   pg_decode  : state -> output vector mapping
`timescale 1ns/1ps
package pwr_gate_seq_pkg;

  typedef enum logic [3:0] {
    ST_INIT    = 4'd0,
    ST_ON      = 4'd1,
    ST_ISO_ON  = 4'd2,
    ST_SAVE    = 4'd3,
    ST_PSW_OFF = 4'd4,
    ST_OFF     = 4'd5,
    ST_PSW_ON  = 4'd6,
    ST_RESTORE = 4'd7,
    ST_ISO_OFF = 4'd8
  } pg_state_e;

  typedef struct packed {
    logic psw_en;
    logic iso;
    logic save;
    logic restore;
    logic dom_rstb;
    logic pwr_ok;
  } pg_out_t;

  function automatic pg_out_t pg_decode(pg_state_e s);
    pg_out_t o;
    o = '0;
    case (s)
      ST_INIT:    begin o.psw_en = 1'b1; o.iso = 1'b1; end
      ST_ON:      begin o.psw_en = 1'b1; o.dom_rstb = 1'b1; o.pwr_ok = 1'b1; end
      ST_ISO_ON:  begin o.psw_en = 1'b1; o.iso = 1'b1; o.dom_rstb = 1'b1; end
      ST_SAVE:    begin o.psw_en = 1'b1; o.iso = 1'b1; o.save = 1'b1; o.dom_rstb = 1'b1; end
      ST_PSW_OFF: begin o.iso = 1'b1; end
      ST_OFF:     begin o.iso = 1'b1; end
      ST_PSW_ON:  begin o.psw_en = 1'b1; o.iso = 1'b1; end
      ST_RESTORE: begin o.psw_en = 1'b1; o.iso = 1'b1; o.restore = 1'b1; o.dom_rstb = 1'b1; end
      ST_ISO_OFF: begin o.psw_en = 1'b1; o.iso = 1'b1; o.dom_rstb = 1'b1; end
      default:    begin o.psw_en = 1'b1; o.iso = 1'b1; end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/pg_dwell_cnt.sv
// pg_dwell_cnt: loadable down-counter with a done flag, shared by the
// sequencer for phase dwell and acknowledge timeout.
//   CLK      : clock, rising edge
//   RSTB     : synchronous active-low reset, loads RST_VAL
//   load     : load load_val this cycle (takes priority over counting)
//   load_val : value to load; done rises load_val+1 cycles after the load
//   done     : count has reached zero (counter holds at zero)
`timescale 1ns/1ps
module pg_dwell_cnt #(
  parameter int unsigned W       = 7,
  parameter int unsigned RST_VAL = 0
) (
  input  logic         CLK,
  input  logic         RSTB,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (!RSTB)
      cnt <= W'(RST_VAL);
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/pwr_gate_seq.sv
// pwr_gate_seq: power-gating sequencer for one switchable domain.
// Orders isolation, retention save/restore, power-switch enable and domain
// reset with programmable dwell per phase.
//   CLK, RSTB           : clock / synchronous active-low reset
//   SLEEP_REQ, WAKE_REQ : level requests from the power manager (WAKE wins)
//   PSW_ACK             : switch chain status, 1 = on
//   PSW_EN, ISO, SAVE, RESTORE, DOM_RSTB : registered domain controls
//   PWR_OK              : domain fully on
//   ERR                 : sticky switch-ack timeout
//   STATE               : current state encoding
`timescale 1ns/1ps
module pwr_gate_seq
  import pwr_gate_seq_pkg::*;
#(
  parameter int unsigned ISO_CYC     = 2,
  parameter int unsigned SAVE_CYC    = 2,
  parameter int unsigned RESTORE_CYC = 2,
  parameter int unsigned RST_CYC     = 4,
  parameter int unsigned TO_CYC      = 64
) (
  input  logic       CLK,
  input  logic       RSTB,
  input  logic       SLEEP_REQ,
  input  logic       WAKE_REQ,
  input  logic       PSW_ACK,
  output logic       PSW_EN,
  output logic       ISO,
  output logic       SAVE,
  output logic       RESTORE,
  output logic       DOM_RSTB,
  output logic       PWR_OK,
  output logic       ERR,
  output logic [3:0] STATE
);

  localparam int unsigned M1   = (ISO_CYC > SAVE_CYC) ? ISO_CYC : SAVE_CYC;
  localparam int unsigned M2   = (M1 > RESTORE_CYC) ? M1 : RESTORE_CYC;
  localparam int unsigned M3   = (M2 > RST_CYC) ? M2 : RST_CYC;
  localparam int unsigned MAXP = (M3 > TO_CYC) ? M3 : TO_CYC;
  localparam int unsigned CW   = $clog2(MAXP + 1);

  pg_state_e     state_q, state_d;
  pg_out_t       out_q;
  logic          err_q;
  logic          err_set;
  logic          init_wait;
  logic          init_reload;
  logic          cnt_load;
  logic [CW-1:0] cnt_val;
  logic          done;

  // Counter preload on entry to a state: dwell-1 for timed phases, TO-1 for
  // acknowledge waits, so done marks the last cycle of the dwell/limit.
  function automatic logic [CW-1:0] load_for(pg_state_e s);
    case (s)
      ST_INIT:               return CW'(RST_CYC - 1);
      ST_ISO_ON, ST_ISO_OFF: return CW'(ISO_CYC - 1);
      ST_SAVE:               return CW'(SAVE_CYC - 1);
      ST_RESTORE:            return CW'(RESTORE_CYC - 1);
      ST_PSW_OFF, ST_PSW_ON: return CW'(TO_CYC - 1);
      default:               return '0;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    err_set     = 1'b0;
    init_reload = 1'b0;
    case (state_q)
      // INIT first runs the reset dwell, then reuses the counter for the
      // ack timeout; init_wait marks the second phase.
      ST_INIT: begin
        if ((done || init_wait) && PSW_ACK)
          state_d = ST_ISO_OFF;
        else if (done) begin
          if (init_wait) err_set     = 1'b1;
          else           init_reload = 1'b1;
        end
      end
      ST_ON:      if (SLEEP_REQ && !WAKE_REQ) state_d = ST_ISO_ON;
      ST_ISO_ON:  if (done) state_d = ST_SAVE;
      ST_SAVE:    if (done) state_d = ST_PSW_OFF;
      ST_PSW_OFF: begin
        if (!PSW_ACK)  state_d = ST_OFF;
        else if (done) err_set = 1'b1;
      end
      ST_OFF:     if (WAKE_REQ) state_d = ST_PSW_ON;
      ST_PSW_ON: begin
        if (PSW_ACK)   state_d = ST_RESTORE;
        else if (done) err_set = 1'b1;
      end
      ST_RESTORE: if (done) state_d = ST_ISO_OFF;
      ST_ISO_OFF: if (done) state_d = ST_ON;
      default:    state_d = ST_INIT;
    endcase
  end

  assign cnt_load = (state_d != state_q) || init_reload;
  assign cnt_val  = init_reload ? CW'(TO_CYC - 1) : load_for(state_d);

  pg_dwell_cnt #(
    .W       (CW),
    .RST_VAL (RST_CYC - 1)
  ) u_cnt (
    .CLK      (CLK),
    .RSTB     (RSTB),
    .load     (cnt_load),
    .load_val (cnt_val),
    .done     (done)
  );

  // Outputs are decoded from the next state into flops so they switch
  // cleanly with STATE.
  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      state_q   <= ST_INIT;
      out_q     <= pg_decode(ST_INIT);
      err_q     <= 1'b0;
      init_wait <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= pg_decode(state_d);
      err_q   <= err_q | err_set;
      if (init_reload) init_wait <= 1'b1;
    end
  end

  assign PSW_EN   = out_q.psw_en;
  assign ISO      = out_q.iso;
  assign SAVE     = out_q.save;
  assign RESTORE  = out_q.restore;
  assign DOM_RSTB = out_q.dom_rstb;
  assign PWR_OK   = out_q.pwr_ok;
  assign ERR      = err_q;
  assign STATE    = state_q;

endmodule

// File: tb/tb_pwr_gate_seq.sv
`timescale 1ns/1ps
module tb_pwr_gate_seq;

  localparam int unsigned ISO = 2, SV = 2, RS = 2, RST = 4, TO = 64;

  // Output table {PSW_EN,ISO,SAVE,RESTORE,DOM_RSTB} per state number.
  localparam logic [4:0] OTAB [9] = '{5'b11000, 5'b10001, 5'b11001, 5'b11101,
                                      5'b01000, 5'b01000, 5'b11000, 5'b11011,
                                      5'b11001};

  logic CLK = 1'b0;
  logic RSTB, SLEEP_REQ, WAKE_REQ, PSW_ACK;
  logic PSW_EN, ISO_o, SAVE, RESTORE, DOM_RSTB, PWR_OK, ERR;
  logic [3:0] STATE;

  pwr_gate_seq #(.ISO_CYC(ISO), .SAVE_CYC(SV), .RESTORE_CYC(RS),
                 .RST_CYC(RST), .TO_CYC(TO)) dut (
    .CLK(CLK), .RSTB(RSTB), .SLEEP_REQ(SLEEP_REQ), .WAKE_REQ(WAKE_REQ),
    .PSW_ACK(PSW_ACK), .PSW_EN(PSW_EN), .ISO(ISO_o), .SAVE(SAVE),
    .RESTORE(RESTORE), .DOM_RSTB(DOM_RSTB), .PWR_OK(PWR_OK), .ERR(ERR),
    .STATE(STATE));

  always #5 CLK = ~CLK;

  int n_assert = 0, n_fail = 0;

  // Reference model: state number plus cycles already spent in it.
  int   ms = 0, mt = 0;
  bit   merr = 1'b0;
  bit   auto_ack = 1'b0;
  int   dly = 1;
  logic [7:0] hist = '1;

  task automatic m_step();
    int el, nxt;
    if (!RSTB) begin ms = 0; mt = 0; merr = 1'b0; return; end
    el  = mt + 1;
    nxt = ms;
    case (ms)
      0: begin
        if (el >= RST && PSW_ACK) nxt = 8;
        else if (!PSW_ACK && el >= RST + TO) merr = 1'b1;
      end
      1: if (SLEEP_REQ && !WAKE_REQ) nxt = 2;
      2: if (el >= ISO) nxt = 3;
      3: if (el >= SV) nxt = 4;
      4: begin
        if (!PSW_ACK) nxt = 5;
        else if (el >= TO) merr = 1'b1;
      end
      5: if (WAKE_REQ) nxt = 6;
      6: begin
        if (PSW_ACK) nxt = 7;
        else if (el >= TO) merr = 1'b1;
      end
      7: if (el >= RS) nxt = 8;
      8: if (el >= ISO) nxt = 1;
      default: nxt = 0;
    endcase
    mt = (nxt != ms) ? 0 : mt + 1;
    ms = nxt;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: advance the model with the same inputs, compare all outputs,
  // then let the switch chain follow PSW_EN with the chosen delay.
  task automatic tick();
    logic [10:0] exp_v, got_v;
    @(posedge CLK);
    m_step();
    #1;
    exp_v = {4'(ms), OTAB[ms], (ms == 1), merr};
    got_v = {STATE, PSW_EN, ISO_o, SAVE, RESTORE, DOM_RSTB, PWR_OK, ERR};
    n_assert++;
    assert (got_v === exp_v) else begin
      n_fail++;
      $error("FAIL model: observed %h expected %h (model state %0d)", got_v, exp_v, ms);
    end
    hist = {hist[6:0], OTAB[ms][4]};
    if (auto_ack) PSW_ACK = hist[dly];
  endtask

  task automatic wait_state(input logic [3:0] s, input string tag);
    int n;
    n = 0;
    while (STATE !== s && n < 200) begin tick(); n++; end
    chk(tag, 32'(STATE), 32'(s));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt_a, cnt_b, last_a, fall_b;
    RSTB = 1'b0; SLEEP_REQ = 1'b0; WAKE_REQ = 1'b0; PSW_ACK = 1'b1;
    #2;
    tick(); tick();
    chk("rst_state", 32'(STATE), 0);
    chk("rst_outs", 32'({PSW_EN, ISO_o, SAVE, RESTORE, DOM_RSTB, PWR_OK, ERR}), 32'b1100000);

    // Release: INIT dwell then ISO_OFF dwell before ON.
    RSTB = 1'b1; auto_ack = 1'b1; dly = 1;
    n = 0;
    do begin tick(); n++; end while (!PWR_OK && n < 50);
    chk("init_to_on_cycles", n, RST + ISO);
    chk("on_iso_dom", 32'({ISO_o, DOM_RSTB}), 32'b01);

    // Sleep: first edge samples the request, then 1+ISO+SAVE+1 to OFF.
    SLEEP_REQ = 1'b1;
    n = 0; cnt_a = 0; cnt_b = 0; last_a = 0; fall_b = 0;
    do begin
      tick(); n++;
      if (SAVE) begin cnt_a++; last_a = n; end
      if (SAVE && !ISO_o) cnt_b++;
      if (!PSW_EN && fall_b == 0) fall_b = n;
    end while (STATE !== 4'd5 && n < 50);
    SLEEP_REQ = 1'b0;
    chk("sleep_latency", n, 1 + (1 + ISO + SV + 1));
    chk("save_width", cnt_a, SV);
    chk("save_without_iso", cnt_b, 0);
    chk("psw_after_save", 32'(fall_b > last_a), 1);
    repeat (3) begin tick(); chk("off_dom_rstb", 32'(DOM_RSTB), 0); end

    // Wake: RESTORE pulse, then ISO drops ISO cycles after it ends.
    WAKE_REQ = 1'b1;
    n = 0; cnt_a = 0; last_a = 0; fall_b = 0;
    do begin
      tick(); n++;
      if (RESTORE) begin cnt_a++; last_a = n; end
      if (!ISO_o && fall_b == 0) fall_b = n;
    end while (STATE !== 4'd1 && n < 50);
    WAKE_REQ = 1'b0;
    chk("wake_latency", n, 1 + (1 + 1 + RS + ISO));
    chk("restore_width", cnt_a, RS);
    chk("iso_after_restore", fall_b - last_a - 1, ISO);

    // Both requests in ON: wake has priority.
    SLEEP_REQ = 1'b1; WAKE_REQ = 1'b1;
    repeat (4) begin tick(); chk("both_stay_on", 32'(STATE), 1); end
    SLEEP_REQ = 1'b0; WAKE_REQ = 1'b0;

    // Wake pulse during SAVE is ignored; domain settles in OFF.
    SLEEP_REQ = 1'b1; tick(); SLEEP_REQ = 1'b0;
    wait_state(4'd3, "reach_save");
    WAKE_REQ = 1'b1; tick(); WAKE_REQ = 1'b0;
    wait_state(4'd5, "reach_off");
    repeat (4) tick();
    chk("off_stays", 32'(STATE), 5);

    // Both requests in OFF: wake next edge.
    SLEEP_REQ = 1'b1; WAKE_REQ = 1'b1;
    tick();
    chk("off_both_wake", 32'(STATE), 6);
    SLEEP_REQ = 1'b0; WAKE_REQ = 1'b0;
    wait_state(4'd1, "back_on");

    // Switch never acknowledges off: ERR after TO cycles in PSW_OFF.
    auto_ack = 1'b0; PSW_ACK = 1'b1;
    SLEEP_REQ = 1'b1; tick(); SLEEP_REQ = 1'b0;
    wait_state(4'd4, "reach_psw_off");
    n = 0;
    while (!ERR && n < 200) begin tick(); n++; end
    chk("timeout_cycles", n, TO);
    chk("timeout_state", 32'(STATE), 4);
    PSW_ACK = 1'b0;
    tick();
    chk("late_ack_off", 32'(STATE), 5);
    chk("err_sticky", 32'(ERR), 1);

    // Reset during PSW_OFF, then recovery without RESTORE.
    auto_ack = 1'b1;
    WAKE_REQ = 1'b1; wait_state(4'd1, "wake_after_err"); WAKE_REQ = 1'b0;
    auto_ack = 1'b0; PSW_ACK = 1'b1;
    SLEEP_REQ = 1'b1; tick(); SLEEP_REQ = 1'b0;
    wait_state(4'd4, "reach_psw_off2");
    RSTB = 1'b0; tick(); RSTB = 1'b1;
    chk("midrst_state", 32'(STATE), 0);
    chk("midrst_outs", 32'({PSW_EN, ISO_o, DOM_RSTB, ERR}), 32'b1100);
    auto_ack = 1'b1;
    n = 0; cnt_a = 0; cnt_b = 0;
    while (!PWR_OK && n < 50) begin
      tick(); n++;
      if (RESTORE) cnt_a++;
      if (STATE === 4'd8) cnt_b++;
    end
    chk("recover_no_restore", cnt_a, 0);
    chk("recover_iso_off", cnt_b, ISO);

    // Random requests, switch delays and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) SLEEP_REQ = ~SLEEP_REQ;
      if ($urandom_range(9) == 0) WAKE_REQ = ~WAKE_REQ;
      if ($urandom_range(63) == 0) dly = int'($urandom_range(3));
      if ($urandom_range(299) == 0) auto_ack = ~auto_ack;
      if (!auto_ack && $urandom_range(15) == 0) PSW_ACK = ~PSW_ACK;
      RSTB = ($urandom_range(399) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
